// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared types and constants for the instruction fetch stage and its
//   integrated program loader.
//   - loader_state_t : RUN (fetching) / LOAD (assembling bytes into the RAM)
//   - BYTE_W         : width of one loader byte
//   - byte_cnt_width : width of a counter that must hold 0..bytes_per_word
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    typedef enum logic {
        LDR_RUN  = 1'b0,
        LDR_LOAD = 1'b1
    } loader_state_t;

    localparam int BYTE_W = 8;

    // The assembler briefly holds the value bytes_per_word (the cycle the
    // last byte of a word arrives), so the counter needs one extra code.
    function automatic int byte_cnt_width(input int bytes_per_word);
        return (bytes_per_word < 1) ? 1 : $clog2(bytes_per_word + 1);
    endfunction

endpackage

// File: rtl/inst_ram_sp.sv
// -----------------------------------------------------------------------------
// inst_ram_sp
//   Single-port synchronous instruction RAM, 2**INST_MEM_WIDTH words of
//   INST_WIDTH bits. One access per cycle: a write, or a registered read.
//   Contents are never cleared; only the read-data register has a
//   synchronous clear so the fetch output comes out of reset at zero.
//
//   Ports:
//     clk    in   clock
//     srst   in   synchronous active-high clear of the read register
//     we     in   write enable (wins over re)
//     re     in   read enable; rdata holds when low
//     addr   in   word address
//     wdata  in   write data
//     rdata  out  registered read data (latency 1)
// -----------------------------------------------------------------------------
module inst_ram_sp #(
    parameter int INST_MEM_WIDTH = 10,
    parameter int INST_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      we,
    input  logic                      re,
    input  logic [INST_MEM_WIDTH-1:0] addr,
    input  logic [INST_WIDTH-1:0]     wdata,
    output logic [INST_WIDTH-1:0]     rdata
);

    localparam int DEPTH = 1 << INST_MEM_WIDTH;

    logic [INST_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register kept separate from the array so tools map it onto the
    // block RAM output register (which supports a synchronous clear).
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata <= '0;
        end else if (re && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/inst_fetch_loader.sv
// -----------------------------------------------------------------------------
// inst_fetch_loader
//   Instruction fetch stage with an integrated program loader.
//   LOAD: bytes from the UART loader are packed big-endian into INST_WIDTH
//         words and written to the internal instruction RAM.
//   RUN : instruction fetched from RAM[pc] with one-cycle latency; pc/pc1
//         are registered alongside so decode sees a matched triple.
//
//   Optional build macro LOADER_CHECKSUM_EN adds output load_checksum, the
//   mod-256 sum of all bytes accepted by the current/last load.
//
//   Ports:
//     CLK            in   clock (posedge)
//     reset          in   synchronous active-low reset
//     pc, pc1        in   fetch address and its companion
//     stall          in   hold all fetch outputs
//     input_data     in   loader byte
//     input_start    in   begin (or restart) a load, one-cycle pulse
//     input_end      in   finish a load, one-cycle pulse
//     input_valid    in   input_data valid this cycle
//     inst           out  fetched instruction
//     inst_valid     out  inst corresponds to pc_next
//     inst_enable    out  1 in RUN, 0 in LOAD
//     pc_next        out  pc registered with inst
//     pc1_next       out  pc1 registered with inst
//     load_words     out  words written by the last/current load
//     load_overflow  out  a load wrote past the last RAM word (sticky)
//     load_checksum  out  (LOADER_CHECKSUM_EN only) byte sum of the load
// -----------------------------------------------------------------------------
module inst_fetch_loader
    import inst_fetch_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 10,
    parameter int INST_WIDTH     = 32   // multiple of 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic                      stall,
    input  logic [7:0]                input_data,
    input  logic                      input_start,
    input  logic                      input_end,
    input  logic                      input_valid,
    output logic [INST_WIDTH-1:0]     inst,
    output logic                      inst_valid,
    output logic                      inst_enable,
    output logic [INST_MEM_WIDTH-1:0] pc_next,
    output logic [INST_MEM_WIDTH-1:0] pc1_next,
    output logic [INST_MEM_WIDTH:0]   load_words,
    output logic                      load_overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]                load_checksum
`endif
);

    localparam int BYTES_PER_WORD = INST_WIDTH / BYTE_W;
    localparam int CNT_W          = byte_cnt_width(BYTES_PER_WORD);
    localparam int DEPTH          = 1 << INST_MEM_WIDTH;
    localparam int LW_W           = INST_MEM_WIDTH + 1;

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    loader_state_t state_reg;
    loader_state_t state_next;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_reg <= LDR_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // input_start has priority over input_end in both states.
    always_comb begin
        state_next  = state_reg;
        inst_enable = 1'b0;
        case (state_reg)
            LDR_RUN: begin
                inst_enable = 1'b1;
                if (input_start) begin
                    state_next = LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                if (input_start) begin
                    state_next = LDR_LOAD;
                end else if (input_end) begin
                    state_next = LDR_RUN;
                end
            end
            default: begin
                state_next = LDR_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte assembler
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]          cnt_reg;
    logic [INST_WIDTH-1:0]     buf_reg;
    logic [INST_MEM_WIDTH-1:0] waddr_reg;
    logic [LW_W-1:0]           load_words_reg;
    logic                      overflow_reg;

    logic                      load_active;
    logic                      byte_take;
    logic [INST_WIDTH-1:0]     buf_eff;
    logic [CNT_W-1:0]          cnt_eff;
    logic                      word_full;
    logic                      word_part;
    logic                      ram_we;
    logic [INST_WIDTH-1:0]     ram_wdata;

    // "eff" values include the byte arriving this cycle, so a full word (or
    // the partial word flushed by input_end) is written in the same cycle.
    always_comb begin
        load_active = (state_reg == LDR_LOAD) && !input_start;
        byte_take   = load_active && input_valid;
        buf_eff     = buf_reg;
        cnt_eff     = cnt_reg;
        if (byte_take) begin
            buf_eff = (buf_reg << BYTE_W) | INST_WIDTH'(input_data);
            cnt_eff = cnt_reg + CNT_W'(1);
        end
        word_full = (cnt_eff == CNT_W'(BYTES_PER_WORD));
        word_part = input_end && (cnt_eff != '0) && !word_full;
        ram_we    = reset && load_active && (word_full || word_part);
        // Left-align the collected bytes; the unused low lanes become zero.
        ram_wdata = buf_eff << (BYTE_W * (BYTES_PER_WORD - int'(cnt_eff)));
    end

    always_ff @(posedge CLK) begin
        if (!reset || input_start) begin
            cnt_reg        <= '0;
            buf_reg        <= '0;
            waddr_reg      <= '0;
            load_words_reg <= '0;
            overflow_reg   <= 1'b0;
        end else if (load_active) begin
            if (ram_we) begin
                cnt_reg        <= '0;
                buf_reg        <= '0;
                waddr_reg      <= waddr_reg + INST_MEM_WIDTH'(1);
                load_words_reg <= load_words_reg + LW_W'(1);
                // Every RAM word already holds data from this load.
                if (load_words_reg >= LW_W'(DEPTH)) begin
                    overflow_reg <= 1'b1;
                end
            end else begin
                cnt_reg <= cnt_eff;
                buf_reg <= buf_eff;
            end
        end
    end

    assign load_words    = load_words_reg;
    assign load_overflow = overflow_reg;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cks_reg;

    always_ff @(posedge CLK) begin
        if (!reset || input_start) begin
            cks_reg <= '0;
        end else if (byte_take) begin
            cks_reg <= cks_reg + input_data;
        end
    end

    assign load_checksum = cks_reg;
`endif

    // ------------------------------------------------------------------
    // Fetch path
    // ------------------------------------------------------------------
    logic                      fetch_en;
    logic [INST_MEM_WIDTH-1:0] ram_addr;
    logic                      inst_valid_reg;
    logic [INST_MEM_WIDTH-1:0] pc_next_reg;
    logic [INST_MEM_WIDTH-1:0] pc1_next_reg;

    // A start pulse in RUN already blanks the fetch so that inst_valid is
    // low on the first LOAD cycle.
    assign fetch_en = reset && (state_reg == LDR_RUN) && !input_start && !stall;
    assign ram_addr = (state_reg == LDR_LOAD) ? waddr_reg : pc;

    inst_ram_sp #(
        .INST_MEM_WIDTH (INST_MEM_WIDTH),
        .INST_WIDTH     (INST_WIDTH)
    ) u_ram (
        .clk   (CLK),
        .srst  (!reset),
        .we    (ram_we),
        .re    (fetch_en),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (inst)
    );

    always_ff @(posedge CLK) begin
        if (!reset) begin
            inst_valid_reg <= 1'b0;
            pc_next_reg    <= '0;
            pc1_next_reg   <= '0;
        end else if ((state_reg == LDR_LOAD) || input_start) begin
            inst_valid_reg <= 1'b0;
        end else if (!stall) begin
            inst_valid_reg <= 1'b1;
            pc_next_reg    <= pc;
            pc1_next_reg   <= pc1;
        end
    end

    assign inst_valid = inst_valid_reg;
    assign pc_next    = pc_next_reg;
    assign pc1_next   = pc1_next_reg;

endmodule

// File: tb/tb_inst_fetch_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_loader
//   Randomised bench with a byte-list reference model of the loader and a
//   fetch scoreboard. Build with +define+LOADER_CHECKSUM_EN to cover the
//   checksum output as well.
// -----------------------------------------------------------------------------
module tb_inst_fetch_loader;

    localparam int AW    = 4;
    localparam int W     = 32;
    localparam int DEPTH = 1 << AW;
    localparam int BPW   = W / 8;

    logic          CLK = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc1;
    logic          stall;
    logic [7:0]    input_data;
    logic          input_start;
    logic          input_end;
    logic          input_valid;
    logic [W-1:0]  inst;
    logic          inst_valid;
    logic          inst_enable;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] pc1_next;
    logic [AW:0]   load_words;
    logic          load_overflow;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    load_checksum;
`endif

    inst_fetch_loader #(
        .INST_MEM_WIDTH (AW),
        .INST_WIDTH     (W)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .pc            (pc),
        .pc1           (pc1),
        .stall         (stall),
        .input_data    (input_data),
        .input_start   (input_start),
        .input_end     (input_end),
        .input_valid   (input_valid),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .inst_enable   (inst_enable),
        .pc_next       (pc_next),
        .pc1_next      (pc1_next),
        .load_words    (load_words),
        .load_overflow (load_overflow)
`ifdef LOADER_CHECKSUM_EN
        ,
        .load_checksum (load_checksum)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0]  inst;
        bit            known;
        logic [AW-1:0] pc;
        logic [AW-1:0] pc1;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: the load is kept as a plain list of accepted bytes;
    // words are derived from it only when they become observable.
    bit         m_run   = 1'b1;
    bit         m_ivalid = 1'b0;
    logic [7:0] m_bytes[$];
    logic [W-1:0] m_mem[DEPTH];
    bit         m_known[DEPTH];
    int         m_lw    = 0;
    logic [7:0] m_cks   = 8'h00;
    exp_t       m_held;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word_at(input int k);
        logic [W-1:0] w;
        w = '0;
        for (int b = 0; b < BPW; b++) begin
            w = w << 8;
            if (k * BPW + b < m_bytes.size()) w = w | W'(m_bytes[k * BPW + b]);
        end
        return w;
    endfunction

    // Place words of the byte list into the memory model; with pad the
    // trailing partial word is written too.
    task automatic commit(input bit pad);
        int nw;
        nw = pad ? (m_bytes.size() + BPW - 1) / BPW : m_bytes.size() / BPW;
        for (int k = 0; k < nw; k++) begin
            m_mem[k % DEPTH]   = word_at(k);
            m_known[k % DEPTH] = 1'b1;
        end
        if (pad) m_lw = nw;
    endtask

    function automatic int lw_exp();
        return m_run ? m_lw : m_bytes.size() / BPW;
    endfunction

    task automatic model();
        if (!reset) begin
            if (!m_run) commit(1'b0);
            m_run = 1'b1; m_bytes.delete(); m_lw = 0; m_cks = 8'h00; m_ivalid = 1'b0;
            m_held = '{inst: '0, known: 1'b1, pc: '0, pc1: '0};
        end else if (m_run) begin
            if (input_start) begin
                m_run = 1'b0; m_bytes.delete(); m_lw = 0; m_cks = 8'h00; m_ivalid = 1'b0;
            end else if (!stall) begin
                m_held = '{inst: m_mem[pc], known: m_known[pc], pc: pc, pc1: pc1};
                m_ivalid = 1'b1;
                sb_q.push_back(m_held);
            end else if (m_ivalid) begin
                sb_q.push_back(m_held);
            end
        end else begin
            if (input_start) begin
                commit(1'b0);
                m_bytes.delete(); m_lw = 0; m_cks = 8'h00;
            end else begin
                if (input_valid) begin
                    m_bytes.push_back(input_data);
                    m_cks = m_cks + input_data;
                end
                if (input_end) begin
                    commit(1'b1);
                    m_run = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_status();
        cmp("inst_enable", inst_enable, m_run);
        cmp("inst_valid", inst_valid, m_ivalid);
        cmp("load_words", load_words, lw_exp());
        cmp("load_overflow", load_overflow, lw_exp() > DEPTH);
`ifdef LOADER_CHECKSUM_EN
        if (m_run) cmp("load_checksum", load_checksum, m_cks);
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        model();
        #1;
        chk_status();
    endtask

    task automatic do_load(input logic [7:0] bs[$], input bit end_with_byte, input bit gaps);
        input_start = 1'b1; input_valid = 1'b0; input_end = 1'b0;
        step();
        input_start = 1'b0;
        foreach (bs[i]) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    input_valid = 1'b0; input_data = 8'($urandom); pc = AW'($urandom);
                    step();
                end
            end
            input_valid = 1'b1;
            input_data  = bs[i];
            input_end   = end_with_byte && (i == bs.size() - 1);
            step();
        end
        input_valid = 1'b0;
        if (!(end_with_byte && bs.size() > 0)) begin
            input_end = 1'b1;
            step();
        end
        input_end = 1'b0;
        $display("load bytes=%0d words=%0d overflow=%0b", bs.size(), load_words, load_overflow);
    endtask

    task automatic fetch(input int a, input bit st);
        pc = AW'(a); pc1 = AW'($urandom); stall = st;
        step();
        stall = 1'b0;
    endtask

    // Scoreboard monitor: every cycle the DUT presents inst_valid, the
    // oldest expected fetch result is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (inst_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_fetch: got pc_next=%0d expected no valid fetch", pc_next);
                end else begin
                    e = sb_q.pop_front();
                    cmp("pc_next", pc_next, e.pc);
                    cmp("pc1_next", pc1_next, e.pc1);
                    if (e.known) cmp("inst", inst, e.inst);
                    $display("fetch pc=%0d pc1=%0d inst=%h", pc_next, pc1_next, inst);
                end
            end
        end
    end

    initial begin
        logic [7:0] bs[$];
        logic [W-1:0] w;

        reset = 1'b0; pc = AW'(5); pc1 = '0; stall = 1'b0;
        input_start = 1'b0; input_end = 1'b0; input_valid = 1'b0; input_data = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        m_held = '{inst: '0, known: 1'b1, pc: '0, pc1: '0};

        // Reset with pc=5 held for two cycles, then release.
        step(); step();
        cmp("rst_pc_next", pc_next, 0);
        cmp("rst_pc1_next", pc1_next, 0);
        cmp("rst_inst", inst, 0);
        reset = 1'b1; pc = AW'(5); pc1 = AW'(9);
        step();
        cmp("rst_release_pc_next", pc_next, 5);

        // Two full words.
        bs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        do_load(bs, 1'b0, 1'b0);
        cmp("two_words", load_words, 2);
        fetch(0, 1'b0);
        cmp("word0", inst, 32'h12345678);
        fetch(1, 1'b0);
        cmp("word1", inst, 32'h9ABCDEF0);

        // Partial word flushed by input_end with a byte in the same cycle.
        bs = '{8'hAA, 8'hBB, 8'hCC};
        do_load(bs, 1'b1, 1'b0);
        cmp("partial_words", load_words, 1);
        fetch(0, 1'b0);
        cmp("partial_word", inst, 32'hAABBCC00);

        // Stall holds outputs while pc moves.
        for (int a = 0; a < 4; a++) fetch(a, 1'b1);
        cmp("stall_pc_next", pc_next, 0);
        cmp("stall_inst", inst, 32'hAABBCC00);

        // Restart after three bytes: next word lands at address 0.
        input_start = 1'b1; step(); input_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            input_valid = 1'b1; input_data = 8'hE0 + 8'(i); step();
        end
        input_valid = 1'b0;
        bs = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(bs, 1'b0, 1'b0);
        fetch(0, 1'b0);
        cmp("restart_word0", inst, 32'h11223344);

        // Overflow: DEPTH+1 words, the last wraps onto address 0.
        bs.delete();
        for (int i = 0; i < (DEPTH + 1) * BPW; i++) bs.push_back(8'($urandom));
        do_load(bs, 1'b0, 1'b1);
        cmp("overflow_flag", load_overflow, 1);
        cmp("overflow_words", load_words, DEPTH + 1);
        fetch(0, 1'b0);
        w = {bs[DEPTH * BPW], bs[DEPTH * BPW + 1], bs[DEPTH * BPW + 2], bs[DEPTH * BPW + 3]};
        cmp("overflow_wrap", inst, w);
        for (int i = 0; i < 2 * DEPTH; i++) fetch($urandom_range(DEPTH - 1), $urandom_range(3) == 0);

        // Simultaneous start+end: start wins, from RUN and from LOAD.
        input_start = 1'b1; input_end = 1'b1; step();
        cmp("start_end_run", inst_enable, 0);
        input_start = 1'b0; input_end = 1'b0;
        input_valid = 1'b1; input_data = 8'h5A; step();
        input_valid = 1'b0;
        input_start = 1'b1; input_end = 1'b1; step();
        cmp("start_end_load", inst_enable, 0);
        input_start = 1'b0;
        step();
        input_end = 1'b0;

        // Reset in the middle of a load after six bytes.
        input_start = 1'b1; step(); input_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            input_valid = 1'b1; input_data = 8'($urandom); step();
        end
        input_valid = 1'b0;
        reset = 1'b0; step(); reset = 1'b1;
        cmp("midload_rst_enable", inst_enable, 1);
        cmp("midload_rst_words", load_words, 0);
        for (int a = 0; a < 3; a++) fetch(a, 1'b0);

        // Checksum pattern (also exercises a plain one-word load).
        bs = '{8'h01, 8'h02, 8'h03, 8'hFF};
        do_load(bs, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        cmp("checksum_05", load_checksum, 8'h05);
`endif
        fetch(0, 1'b0);
        cmp("cks_word", inst, 32'h010203FF);

        // Randomised loads followed by randomised fetch/stall traffic.
        for (int r = 0; r < 6; r++) begin
            bs.delete();
            for (int i = 0; i < $urandom_range(DEPTH * BPW + 6); i++) bs.push_back(8'($urandom));
            do_load(bs, $urandom_range(1) == 1, 1'b1);
            for (int i = 0; i < 24; i++) fetch($urandom_range(DEPTH - 1), $urandom_range(3) == 0);
        end

        step(); step();
        @(negedge CLK); #1;
        cmp("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
